lsu: RTL and testbench
======================

# lsu

Load/store unit directly downstream of the two-lane ALU: consumes the lane-1 result (`a + b`, the effective address) together with store data and the RV32I `funct3` size code, drives a single-outstanding word-wide memory bus, and returns sign/zero-extended load data to writeback. Stores perform byte-lane steering and strobe generation. A small FSM sequences one or two bus transactions per access.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  access request from execute
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid && req_ready`
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU (BU/HU loads only)
- `req_addr`  in  32  effective address (ALU lane-1 `d`)
- `req_wdata`  in  32  store data (rs2), LSB-justified
- `done`  out  1  one-cycle pulse: access finished (success or fault)
- `rdata`  out  32  extended load result, valid with `done`; 0 for stores and faults
- `fault`  out  1  with `done`: misaligned or illegal `funct3`
- `mem_valid`  out  1  bus request; held until `mem_ready`
- `mem_ready`  in  1  bus accepts request this cycle
- `mem_we`  out  1  write request
- `mem_addr`  out  32  word address, `[1:0]` always 0
- `mem_wstrb`  out  4  byte strobes (0 for reads)
- `mem_wdata`  out  32  lane-shifted write data
- `mem_rvalid`  in  1  response (read data or write ack); never in the same cycle as its `mem_ready`
- `mem_rdata`  in  32  read word, valid with `mem_rvalid`

## Operation
- States: IDLE, REQ, RESP, REQ2, RESP2, DONE.
- IDLE: on accept, latch addr/data/size/type, compute `off = addr[1:0]`, `len` = 1/2/4. Illegal `funct3` (3, 6, 7; any of 4/5 with store) or unsupported misalignment -> DONE with `fault`=1, no bus traffic. Else -> REQ.
- REQ: `mem_valid`=1, `mem_addr = {addr[31:2],2'b00}`, `mem_wstrb = ((1<<len)-1) << off` truncated to 4 bits, `mem_wdata = wdata << 8*off`. On `mem_ready` -> RESP.
- RESP: on `mem_rvalid`, capture `mem_rdata` into low buffer; -> REQ2 if split, else DONE.
- REQ2/RESP2: second word at `mem_addr + 4`, strobes/data are the bits shifted out above byte 3; response captured into high buffer; -> DONE.
- DONE: `done`=1 for exactly one cycle; `rdata = extend({hi,lo} >> 8*off)` to `len` bytes, sign-extend for B/H, zero-extend for BU/HU/W -> IDLE.
- Split condition: `off + len > 4`.
- Request-side outputs (`mem_*`) hold stable while `mem_valid && !mem_ready`.
- `mem_rvalid` outside RESP/RESP2 is ignored.
- Reset: state IDLE; `req_ready`=1 (the cycle after reset releases); `done`, `fault`, `mem_valid`, `mem_we`=0; `rdata`, `mem_addr`, `mem_wstrb`, `mem_wdata`=0. Reset mid-transaction abandons it; `mem_valid` low from the next cycle; the late response is ignored.

## Timing
- Single aligned access, zero-wait bus: accept cycle 0, `mem_valid` cycle 1 (`mem_ready`=1), `mem_rvalid` cycle 2, `done` cycle 3; `req_ready` high again cycle 4.
- Split access adds 2 cycles minimum (`done` cycle 5).
- Fault: accept cycle 0, `done`+`fault` cycle 1.
- All outputs registered or decoded directly from state; no combinational path from `mem_*` inputs to `mem_*` outputs.

## Configuration
- `LSU_MISALIGNED_EN` defined: any misaligned H/W access is legal; within-word cases use one transaction, word-crossing cases split per above.
- Undefined: any access with `addr % len != 0` faults; REQ2/RESP2 unreachable and may be removed by synthesis.

## Structure
- `lsu_pkg`: `funct3` width constants, FSM state enum, `size_of(funct3)` and `is_legal(funct3, store)` functions.
- Sub-module `lsu_align`: combinational store lane-shift/strobe generation and load extract/extend; the FSM lives in `lsu`.

## Test plan
- LW 0x1000, bus returns 0xDEADBEEF, zero-wait -> `done` at cycle 3, `rdata`=0xDEADBEEF, `fault`=0.
- LB 0x1003 with word 0x80112233 -> `rdata`=0xFFFFFF80; LBU same -> 0x00000080.
- SH 0x2002 data 0x0000ABCD -> `mem_addr`=0x2000, `mem_wstrb`=0b1100, `mem_wdata`=0xABCD0000.
- LW 0x1006: with macro -> two reads 0x1004 (0x44332211) then 0x1008 (0x88776655), `rdata`=0x66554433; without -> `fault`=1 at cycle 1, `mem_valid` never high.
- `mem_ready` low 3 cycles -> `mem_addr`/`mem_wdata`/`mem_wstrb` constant throughout; `req_ready` stays low.
- `rst` asserted while in RESP -> next cycle `mem_valid`=0, `req_ready`=1; subsequent `mem_rvalid` produces no `done`.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared width codes, FSM state encoding and size/legality
//               helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] c_F3_B  = 3'd0;
    localparam logic [2:0] c_F3_H  = 3'd1;
    localparam logic [2:0] c_F3_W  = 3'd2;
    localparam logic [2:0] c_F3_BU = 3'd4;
    localparam logic [2:0] c_F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_REQ2  = 3'd3,
        S_RESP2 = 3'd4,
        S_DONE  = 3'd5
    } lsu_state_t;

    // Access length in bytes; unknown codes report 4 but are rejected by is_legal.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            c_F3_B, c_F3_BU: return 3'd1;
            c_F3_H, c_F3_HU: return 3'd2;
            default:         return 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] funct3, input logic store);
        case (funct3)
            c_F3_B, c_F3_H, c_F3_W: return 1'b1;
            c_F3_BU, c_F3_HU:       return !store;
            default:                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational store lane steering / strobe generation and
//               load byte extraction with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_off,
    input  logic [2:0]  i_st_len,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_strb_lo,
    output logic [3:0]  o_st_strb_hi,
    output logic [31:0] o_st_data_lo,
    output logic [31:0] o_st_data_hi,
    input  logic [1:0]  i_ld_off,
    input  logic [2:0]  i_ld_funct3,
    input  logic [31:0] i_ld_lo,
    input  logic [23:0] i_ld_hi,
    output logic [31:0] o_ld_data
);

    logic [3:0]  w_mask;
    logic [7:0]  w_strb;
    logic [63:0] w_sdata;
    logic [55:0] w_cat;
    logic [31:0] w_word;

    always_comb begin
        case (i_st_len)
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_strb = {4'b0000, w_mask} << i_st_off;

    always_comb begin
        case (i_st_off)
            2'd0:    w_sdata = {32'd0, i_st_wdata};
            2'd1:    w_sdata = {24'd0, i_st_wdata, 8'd0};
            2'd2:    w_sdata = {16'd0, i_st_wdata, 16'd0};
            default: w_sdata = {8'd0,  i_st_wdata, 24'd0};
        endcase
    end

    assign o_st_strb_lo = w_strb[3:0];
    assign o_st_strb_hi = w_strb[7:4];
    assign o_st_data_lo = w_sdata[31:0];
    assign o_st_data_hi = w_sdata[63:32];

    // A split access never reaches past byte 2 of the upper word.
    assign w_cat = {i_ld_hi, i_ld_lo};

    always_comb begin
        case (i_ld_off)
            2'd0:    w_word = w_cat[31:0];
            2'd1:    w_word = w_cat[39:8];
            2'd2:    w_word = w_cat[47:16];
            default: w_word = w_cat[55:24];
        endcase
    end

    always_comb begin
        case (i_ld_funct3)
            c_F3_B:  o_ld_data = {{24{w_word[7]}}, w_word[7:0]};
            c_F3_H:  o_ld_data = {{16{w_word[15]}}, w_word[15:0]};
            c_F3_BU: o_ld_data = {24'd0, w_word[7:0]};
            c_F3_HU: o_ld_data = {16'd0, w_word[15:0]};
            default: o_ld_data = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit with a single-outstanding word bus; one or
//               two bus transactions per access. Define LSU_MISALIGNED_EN to
//               accept misaligned H/W accesses (word-crossing ones split).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  r_state;
    logic        r_req_ready;
    logic        r_done;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic        r_mem_valid;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_store;
    logic        r_split;
    logic [3:0]  r_wstrb_hi;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_lo;
    logic [23:0] r_hi;

    logic [2:0]  w_len;
    logic [1:0]  w_off;
    logic        w_misaligned;
    logic        w_split;
    logic        w_legal;
    logic        w_accept;
    logic [3:0]  w_strb_lo;
    logic [3:0]  w_strb_hi;
    logic [31:0] w_data_lo;
    logic [31:0] w_data_hi;
    logic [31:0] w_ld_lo;
    logic [23:0] w_ld_hi;
    logic [31:0] w_ld_data;

    assign w_len = size_of(req_funct3);
    assign w_off = req_addr[1:0];

`ifdef LSU_MISALIGNED_EN
    assign w_misaligned = 1'b0;
    assign w_split      = ({1'b0, w_off} + w_len) > 3'd4;
`else
    assign w_misaligned = ((w_len == 3'd2) && w_off[0]) ||
                          ((w_len == 3'd4) && (w_off != 2'b00));
    assign w_split      = 1'b0;
`endif

    assign w_legal  = is_legal(req_funct3, req_store) && !w_misaligned;
    assign w_accept = req_valid && r_req_ready && (r_state == S_IDLE);

    // The word arriving this cycle is fed straight in so rdata registers with done.
    assign w_ld_lo = (r_state == S_RESP)  ? mem_rdata       : r_lo;
    assign w_ld_hi = (r_state == S_RESP2) ? mem_rdata[23:0] : r_hi;

    lsu_align u_align (
        .i_st_off     (w_off),
        .i_st_len     (w_len),
        .i_st_wdata   (req_wdata),
        .o_st_strb_lo (w_strb_lo),
        .o_st_strb_hi (w_strb_hi),
        .o_st_data_lo (w_data_lo),
        .o_st_data_hi (w_data_hi),
        .i_ld_off     (r_off),
        .i_ld_funct3  (r_f3),
        .i_ld_lo      (w_ld_lo),
        .i_ld_hi      (w_ld_hi),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_rdata     <= 32'd0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_off       <= 2'd0;
            r_f3        <= 3'd0;
            r_store     <= 1'b0;
            r_split     <= 1'b0;
            r_wstrb_hi  <= 4'd0;
            r_wdata_hi  <= 32'd0;
            r_lo        <= 32'd0;
            r_hi        <= 24'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_rdata     <= 32'd0;
                        r_off       <= w_off;
                        r_f3        <= req_funct3;
                        r_store     <= req_store;
                        r_split     <= w_split;
                        r_wstrb_hi  <= req_store ? w_strb_hi : 4'd0;
                        r_wdata_hi  <= req_store ? w_data_hi : 32'd0;
                        r_lo        <= 32'd0;
                        r_hi        <= 24'd0;
                        if (!w_legal) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= req_store;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wstrb <= req_store ? w_strb_lo : 4'd0;
                            r_mem_wdata <= req_store ? w_data_lo : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        if (r_split) begin
                            r_lo        <= mem_rdata;
                            r_state     <= S_REQ2;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= r_store;
                            r_mem_addr  <= r_mem_addr + 32'd4;
                            r_mem_wstrb <= r_wstrb_hi;
                            r_mem_wdata <= r_wdata_hi;
                        end else begin
                            r_lo    <= mem_rdata;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_rdata <= r_store ? 32'd0 : w_ld_data;
                        end
                    end
                end
                S_REQ2: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_state     <= S_RESP2;
                    end
                end
                S_RESP2: begin
                    if (mem_rvalid) begin
                        r_hi    <= mem_rdata[23:0];
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_rdata <= r_store ? 32'd0 : w_ld_data;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_fault     <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign fault     = r_fault;
    assign rdata     = r_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed vector bench for lsu; expectations follow the
//               LSU_MISALIGNED_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .done       (done),
        .rdata      (rdata),
        .fault      (fault),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        ef;
        logic [31:0] erd;
        int          ecyc;
        int          entx;
        logic [31:0] ea0;
        logic [31:0] ed0;
        logic [3:0]  es0;
        logic [31:0] ea1;
        logic [31:0] ed1;
        logic [3:0]  es1;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    logic        g_fault;
    logic [31:0] g_rdata;
    int          g_dc;
    int          g_ntx;
    logic [31:0] g_a [2];
    logic [31:0] g_d [2];
    logic [3:0]  g_s [2];
    logic        g_we [2];
    logic        g_hold_bad;
    logic        g_ready_bad;
    logic        g_ready_after;
    logic        g_done_after;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drives one request and plays a bus with wait_n stall cycles per transfer.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] w0, input logic [31:0] w1,
                          input int wait_n);
        int  waited;
        int  idx;
        logic pending;
        waited = 0;
        pending = 1'b0;
        g_ntx = 0;
        g_dc = -1;
        g_fault = 1'bx;
        g_rdata = 32'hxxxxxxxx;
        g_hold_bad = 1'b0;
        g_ready_bad = 1'b0;
        for (int k = 0; k < 2; k++) begin
            g_a[k] = 32'd0; g_d[k] = 32'd0; g_s[k] = 4'd0; g_we[k] = 1'b0;
        end
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            if (done) begin
                g_fault = fault;
                g_rdata = rdata;
                g_dc = cyc;
                break;
            end
            if (req_ready) g_ready_bad = 1'b1;
            if (pending) begin
                mem_rvalid = 1'b1;
                mem_rdata = (g_ntx == 1) ? w0 : w1;
                pending = 1'b0;
            end else if (mem_valid) begin
                idx = (g_ntx > 1) ? 1 : g_ntx;
                if (waited == 0) begin
                    g_a[idx] = mem_addr; g_d[idx] = mem_wdata;
                    g_s[idx] = mem_wstrb; g_we[idx] = mem_we;
                end else if (mem_addr !== g_a[idx] || mem_wdata !== g_d[idx] ||
                             mem_wstrb !== g_s[idx] || mem_we !== g_we[idx]) begin
                    g_hold_bad = 1'b1;
                end
                if (waited >= wait_n) begin
                    mem_ready = 1'b1;
                    pending = 1'b1;
                    g_ntx++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        g_ready_after = req_ready;
        g_done_after = done;
    endtask

    vec_t vecs [15];

    initial begin
        // Field order: st f3 addr wd w0 w1 | ef erd ecyc entx ea0 ed0 es0 ea1 ed1 es1
        vecs[0]  = '{1'b0, 3'd2, 32'h1000, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1, 32'h1000, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[1]  = '{1'b0, 3'd0, 32'h1003, 32'h0, 32'h80112233, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1, 32'h1000, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[2]  = '{1'b0, 3'd4, 32'h1003, 32'h0, 32'h80112233, 32'h0, 1'b0, 32'h00000080, 3, 1, 32'h1000, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[3]  = '{1'b1, 3'd1, 32'h2002, 32'h0000ABCD, 32'h0, 32'h0, 1'b0, 32'h0, 3, 1, 32'h2000, 32'hABCD0000, 4'hC, 32'h0, 32'h0, 4'h0};
        vecs[4]  = '{1'b0, 3'd1, 32'h1002, 32'h0, 32'h80112233, 32'h0, 1'b0, 32'hFFFF8011, 3, 1, 32'h1000, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[5]  = '{1'b0, 3'd5, 32'h1000, 32'h0, 32'h80112233, 32'h0, 1'b0, 32'h00002233, 3, 1, 32'h1000, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[6]  = '{1'b1, 3'd0, 32'h3001, 32'h000000A5, 32'h0, 32'h0, 1'b0, 32'h0, 3, 1, 32'h3000, 32'h0000A500, 4'h2, 32'h0, 32'h0, 4'h0};
        vecs[7]  = '{1'b1, 3'd2, 32'h3000, 32'h12345678, 32'h0, 32'h0, 1'b0, 32'h0, 3, 1, 32'h3000, 32'h12345678, 4'hF, 32'h0, 32'h0, 4'h0};
        vecs[8]  = '{1'b0, 3'd3, 32'h1000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[9]  = '{1'b1, 3'd4, 32'h1000, 32'hFF, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[10] = '{1'b0, 3'd6, 32'h1000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
`ifdef LSU_MISALIGNED_EN
        vecs[11] = '{1'b0, 3'd2, 32'h1006, 32'h0, 32'h44332211, 32'h88776655, 1'b0, 32'h66554433, 5, 2, 32'h1004, 32'h0, 4'h0, 32'h1008, 32'h0, 4'h0};
        vecs[12] = '{1'b0, 3'd1, 32'h1001, 32'h0, 32'h44332211, 32'h0, 1'b0, 32'h00003322, 3, 1, 32'h1000, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[13] = '{1'b0, 3'd1, 32'h1003, 32'h0, 32'h44332211, 32'h88776655, 1'b0, 32'h00005544, 5, 2, 32'h1000, 32'h0, 4'h0, 32'h1004, 32'h0, 4'h0};
        vecs[14] = '{1'b1, 3'd2, 32'h2003, 32'hAABBCCDD, 32'h0, 32'h0, 1'b0, 32'h0, 5, 2, 32'h2000, 32'hDD000000, 4'h8, 32'h2004, 32'h00AABBCC, 4'h7};
`else
        vecs[11] = '{1'b0, 3'd2, 32'h1006, 32'h0, 32'h44332211, 32'h88776655, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[12] = '{1'b0, 3'd1, 32'h1001, 32'h0, 32'h44332211, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[13] = '{1'b0, 3'd1, 32'h1003, 32'h0, 32'h44332211, 32'h88776655, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[14] = '{1'b1, 3'd2, 32'h2003, 32'hAABBCCDD, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset done",      {31'd0, done},      32'd0);
        chk("reset fault",     {31'd0, fault},     32'd0);
        chk("reset mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("reset mem_we",    {31'd0, mem_we},    32'd0);
        chk("reset rdata",     rdata,              32'd0);
        chk("reset mem_addr",  mem_addr,           32'd0);
        chk("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("reset mem_wdata", mem_wdata,          32'd0);

        for (int i = 0; i < 15; i++) begin
            access(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].w0, vecs[i].w1, 0);
            chk($sformatf("v%0d fault", i),       {31'd0, g_fault}, {31'd0, vecs[i].ef});
            chk($sformatf("v%0d rdata", i),       g_rdata, vecs[i].erd);
            chk($sformatf("v%0d done_cycle", i),  g_dc, vecs[i].ecyc);
            chk($sformatf("v%0d bus_txns", i),    g_ntx, vecs[i].entx);
            chk($sformatf("v%0d done_pulse", i),  {31'd0, g_done_after}, 32'd0);
            chk($sformatf("v%0d ready_after", i), {31'd0, g_ready_after}, 32'd1);
            if (vecs[i].entx >= 1) begin
                chk($sformatf("v%0d addr0", i),  g_a[0], vecs[i].ea0);
                chk($sformatf("v%0d wdata0", i), g_d[0], vecs[i].ed0);
                chk($sformatf("v%0d wstrb0", i), {28'd0, g_s[0]}, {28'd0, vecs[i].es0});
                chk($sformatf("v%0d we0", i),    {31'd0, g_we[0]}, {31'd0, vecs[i].st});
            end
            if (vecs[i].entx == 2) begin
                chk($sformatf("v%0d addr1", i),  g_a[1], vecs[i].ea1);
                chk($sformatf("v%0d wdata1", i), g_d[1], vecs[i].ed1);
                chk($sformatf("v%0d wstrb1", i), {28'd0, g_s[1]}, {28'd0, vecs[i].es1});
            end
        end

        // Bus stalls three cycles: request fields must hold and req_ready stays low.
        access(1'b1, 3'd1, 32'h2002, 32'h0000ABCD, 32'h0, 32'h0, 3);
        chk("stall hold",       {31'd0, g_hold_bad},  32'd0);
        chk("stall req_ready",  {31'd0, g_ready_bad}, 32'd0);
        chk("stall done_cycle", g_dc, 6);
        chk("stall wstrb",      {28'd0, g_s[0]}, 32'hC);
        chk("stall wdata",      g_d[0], 32'hABCD0000);
        access(1'b0, 3'd2, 32'h1000, 32'h0, 32'h0BADF00D, 32'h0, 3);
        chk("stall load rdata", g_rdata, 32'h0BADF00D);
        chk("stall load ready", {31'd0, g_ready_bad}, 32'd0);

        // Stray response while idle must not complete anything.
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("idle rvalid done",  {31'd0, done}, 32'd0);
        chk("idle rvalid ready", {31'd0, req_ready}, 32'd1);

        // Reset while waiting for the response abandons the access.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst seq mem_valid", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst mid mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst mid req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (done) saw_done = 1'b1;
                @(posedge clk); #1;
            end
            chk("rst late resp done", {31'd0, saw_done}, 32'd0);
        end
        access(1'b0, 3'd2, 32'h1000, 32'h0, 32'hCAFEF00D, 32'h0, 0);
        chk("post rst rdata", g_rdata, 32'hCAFEF00D);
        chk("post rst cycle", g_dc, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
